// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU with a registered result and start/done handshake.
// Single-cycle ops complete one cycle after start; DIV runs a WIDTH-cycle
// restoring divider while busy is held high.
//
// Handshake: an op is accepted on a rising edge where start=1 and busy=0.
// Operands and code are sampled at that edge. done pulses for exactly one
// cycle when the op's outputs become valid; start while busy=1 is dropped.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             zero,
  output logic             wen,
  output logic             divzero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] WIDTH_V = (WIDTH + 1)'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_MOVZ = 4'b0100;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_LSL  = 4'b1000;
  localparam logic [3:0] OP_LSR  = 4'b1001;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             zero_q, zero_d;
  logic             wen_q, wen_d;
  logic             divzero_q, divzero_d;
  logic             done_q, done_d;
  // Dividend register shifts left each step; quotient bits fill in from the
  // LSB, so after WIDTH steps it holds the quotient.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_wen;
  logic [WIDTH:0]   step_shift;
  logic [WIDTH:0]   step_diff;
  logic             step_qbit;
  logic [WIDTH:0]   step_prem;

  // Single-cycle operation result and writeback enable.
  always_comb begin
    alu_res = '0;
    alu_wen = 1'b1;
    unique case (alucontrol)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_MOVZ: begin
        alu_res = a;
        alu_wen = (b == '0);
      end
      OP_SLT:  alu_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      OP_LSL:  alu_res = ({1'b0, b} >= WIDTH_V) ? '0 : (a << b);
      OP_LSR:  alu_res = ({1'b0, b} >= WIDTH_V) ? '0 : (a >> b);
      // DIV is handled by the FSM; undefined codes produce 0 with no writeback.
      default: begin
        alu_res = '0;
        alu_wen = 1'b0;
      end
    endcase
  end

  // One restoring-division step, MSB of the dividend first.
  always_comb begin
    step_shift = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    step_diff  = step_shift - {1'b0, dvs_q};
    step_qbit  = ~step_diff[WIDTH];
    step_prem  = step_qbit ? step_diff : step_shift;
  end

  // Next-state and output-register logic for the IDLE/DIV controller.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    zero_d      = zero_q;
    wen_d       = wen_q;
    divzero_d   = divzero_q;
    done_d      = 1'b0;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (alucontrol == OP_DIV) begin
            if (b == '0) begin
              // Divide by zero finishes immediately and blocks writeback.
              result_d    = '1;
              remainder_d = a;
              zero_d      = 1'b0;
              wen_d       = 1'b0;
              divzero_d   = 1'b1;
              done_d      = 1'b1;
            end else begin
              dvd_d   = a;
              dvs_d   = b;
              prem_d  = '0;
              cnt_d   = CW'(WIDTH);
              state_d = S_DIV;
            end
          end else begin
            result_d    = alu_res;
            remainder_d = '0;
            zero_d      = (alu_res == '0);
            wen_d       = alu_wen;
            divzero_d   = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      S_DIV: begin
        dvd_d  = {dvd_q[WIDTH-2:0], step_qbit};
        prem_d = step_prem;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d    = {dvd_q[WIDTH-2:0], step_qbit};
          remainder_d = step_prem[WIDTH-1:0];
          zero_d      = ({dvd_q[WIDTH-2:0], step_qbit} == '0);
          wen_d       = 1'b1;
          divzero_d   = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; synchronous active-low reset abandons any divide.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      remainder_q <= '0;
      zero_q      <= 1'b1;
      wen_q       <= 1'b0;
      divzero_q   <= 1'b0;
      done_q      <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      zero_q      <= zero_d;
      wen_q       <= wen_d;
      divzero_q   <= divzero_d;
      done_q      <= done_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      cnt_q       <= cnt_d;
    end
  end

  assign result    = result_q;
  assign remainder = remainder_q;
  assign zero      = zero_q;
  assign wen       = wen_q;
  assign divzero   = divzero_q;
  assign busy      = (state_q == S_DIV);
  assign done      = done_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential ALU that executes the 4-bit `alucontrol` code produced by the ALU decoder and returns a registered result with a `start`/`done` handshake. Most operations take one cycle. DIV runs as a multi-cycle restoring divider, during which the block holds `busy`. It sits in the execute stage between the decoder/register-read outputs and writeback/branch logic.

## Interface
Parameters:
- `WIDTH`, 4: datapath width in bits; must be ≥ 2.

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock.
- `reset`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `start`  in  1  request to execute; accepted only while `busy`=0.
- `alucontrol`  in  4  operation code, sampled with `start`.
- `a`  in  WIDTH  operand A, sampled with `start`.
- `b`  in  WIDTH  operand B, sampled with `start`.
- `result`  out  WIDTH  registered result; quotient for DIV.
- `remainder`  out  WIDTH  DIV remainder; 0 for all other ops.
- `zero`  out  1  `result`==0, updated together with `result`.
- `wen`  out  1  writeback permitted for this result.
- `divzero`  out  1  DIV attempted with `b`==0.
- `busy`  out  1  divide in progress.
- `done`  out  1  one-cycle pulse: outputs valid for the accepted op.

## Operation
- Codes (all others are undefined: `result`=0, `wen`=0):
  - 0000 ADD: `a`+`b` mod 2^WIDTH.
  - 0001 SUB: `a`−`b` mod 2^WIDTH.
  - 0010 AND.
  - 0011 OR.
  - 0111 NOR.
  - 0100 MOVZ: `result`=`a`; `wen`=(`b`==0).
  - 0101 DIV: unsigned divide.
  - 0110 SLT: signed two's-complement compare; `result`=1 if `a`<`b`, else 0.
  - 1000 LSL: `a`<<`b`.
  - 1001 LSR: logical `a`>>`b`.
- Shifts: shift amount is the full unsigned value of `b`; if `b`≥WIDTH, `result`=0.
- `wen`=1 for all defined ops except MOVZ with `b`≠0 and DIV by zero.
- FSM states:
  - IDLE → IDLE on `start` with a non-DIV op, or DIV with `b`==0.
  - IDLE → DIV on `start` with DIV and `b`≠0.
  - DIV → IDLE after WIDTH iterations.
- DIV state:
  - Latch the dividend and divisor, clear the partial remainder, and load an iteration counter with WIDTH.
  - Each cycle, perform one restoring step, MSB first: shift the partial remainder left, bringing in the next dividend bit; subtract the divisor; keep the difference if it is non-negative and set that quotient bit to 1, else restore.
  - The partial remainder is WIDTH+1 bits wide internally.
- Divide by zero: `result`=all ones, `remainder`=`a`, `divzero`=1, `wen`=0. Completes in one cycle; the block never enters DIV.
- `result`, `remainder`, `zero`, `wen`, and `divzero` hold their values until the next accepted `start`. `divzero` is cleared by any accepted non-faulting op.
- `start` while `busy`=1 is ignored entirely: no queueing, and the latched operands are unaffected.

## Timing
- Reset (`reset`=0 at an edge): state IDLE; `result`=0, `remainder`=0, `zero`=1, `wen`=0, `divzero`=0, `busy`=0, `done`=0. An in-flight divide is abandoned with no `done`.
- Single-cycle ops: `start` sampled at edge E0 → outputs valid and `done`=1 during the cycle after E0. `done` falls at E1 unless a new `start` is accepted at E1.
- DIV: `start` sampled at E0 → `busy`=1 after E0. Iterations occur at E1..E_WIDTH. At E_WIDTH, the outputs update, `done`=1, and `busy`=0.
- Back-to-back operation:
  - `start` is accepted in the same cycle that `done` is high, since `busy`=0 by then.
  - Throughput is one op per cycle for non-DIV ops and one DIV per WIDTH cycles.
- `busy` and `done` are never both 1.
- Reset takes priority over `start` at the same edge.

## Test plan
Directed scenarios, all at WIDTH=4:
- ADD `a`=9, `b`=8 → `result`=1, `zero`=0, `wen`=1, `done` one cycle after `start`.
- SUB `a`=5, `b`=5 → `result`=0, `zero`=1. SLT `a`=15, `b`=1 → `result`=1. LSL `a`=3, `b`=2 → 12. LSL `a`=3, `b`=5 → 0. LSR `a`=12, `b`=3 → 1.
- DIV `a`=13, `b`=3:
  - `busy`=1 for 4 cycles, then `done` with `result`=4, `remainder`=1, `wen`=1.
  - A `start` (ADD) pulsed mid-divide is ignored.
- DIV `a`=7, `b`=0 → the next cycle shows `result`=15, `remainder`=7, `divzero`=1, `wen`=0, `busy` never asserted.
- MOVZ `a`=6, `b`=0 → `result`=6, `wen`=1. MOVZ `a`=6, `b`=2 → `result`=6, `wen`=0. Undefined code 1111 → `result`=0, `wen`=0.
- Reset mid-divide (`reset`=0 at E2 of DIV 13/3):
  - All outputs return to reset values, with no `done` pulse.
  - A following ADD 1+1 completes normally with `result`=2.
